// File: rtl/sprite_rom_arbiter_pkg.sv
// rtl/sprite_rom_arbiter_pkg.sv - shared types and constants for the sprite ROM arbiter
package sprite_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int ID_W        = $clog2(NUM_REQ_DEF);

  typedef logic [ID_W-1:0] req_id_t;

  localparam req_id_t REQ_PLAYER = req_id_t'(0);
  localparam req_id_t REQ_MONEY  = req_id_t'(1);
  localparam req_id_t REQ_CAR    = req_id_t'(2);
  localparam req_id_t REQ_TEXT   = req_id_t'(3);

  typedef struct packed {
    logic    v;
    req_id_t id;
  } arb_tag_t;

  function automatic req_id_t next_ptr(input req_id_t id);
    return (int'(id) == NUM_REQ_DEF - 1) ? '0 : id + req_id_t'(1);
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// rtl/sprite_rom_arbiter_if.sv - requester and ROM signal bundle for the sprite ROM arbiter
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 6
);
  logic                      FrameStart;
  logic [NUM_REQ-1:0]        Req;
  logic [NUM_REQ*ADDR_W-1:0] Addr;
  logic [NUM_REQ-1:0]        Grant;
  logic [ADDR_W-1:0]         RomAddr;
  logic                      RomRden;
  logic [DATA_W-1:0]         RomData;
  logic [DATA_W-1:0]         RdData;
  logic [NUM_REQ-1:0]        RdValid;
  logic                      Busy;

  modport slave (
    input  FrameStart, Req, Addr, RomData,
    output Grant, RomAddr, RomRden, RdData, RdValid, Busy
  );

  modport master (
    output FrameStart, Req, Addr, RomData,
    input  Grant, RomAddr, RomRden, RdData, RdValid, Busy
  );
endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// rtl/sprite_rom_arbiter_rr_pick.sv - combinational round-robin picker starting at ptr_i
module sprite_arb_rr_pick
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  req_id_t            ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output req_id_t            id_o,
  output logic               any_o
);

  req_id_t idx;

  always_comb begin
    grant_o = '0;
    id_o    = '0;
    any_o   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = req_id_t'((int'(ptr_i) + k) % NUM_REQ);
      if (!any_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        id_o         = idx;
        any_o        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - shares one sprite ROM among the pixel fetchers, tags data to owner
// Optional: SPRITE_ARB_PRIO0_EN gives the player (Req[0]) fixed priority over the others.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 6,
  parameter int ROM_LAT = 1
) (
  input logic                 Clk,
  input logic                 Reset_n,
  sprite_rom_arbiter_if.slave bus
);

  req_id_t            ptr_q, ptr_d, arb_ptr;
  logic [NUM_REQ-1:0] pick_req, pick_grant, grant;
  req_id_t            pick_id, win_id;
  logic               pick_any, win_any;

  logic [ADDR_W-1:0]  rom_addr_q;
  logic               rom_rden_q;
  arb_tag_t           tag_q [ROM_LAT+1];
  logic [DATA_W-1:0]  rd_data_q;
  logic [NUM_REQ-1:0] rd_valid_q;
  logic               busy;

  // FrameStart restarts the rotation in the very cycle it is seen
  assign arb_ptr = bus.FrameStart ? '0 : ptr_q;

`ifdef SPRITE_ARB_PRIO0_EN
  assign pick_req = {bus.Req[NUM_REQ-1:1], 1'b0};
`else
  assign pick_req = bus.Req;
`endif

  sprite_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (pick_req),
    .ptr_i   (arb_ptr),
    .grant_o (pick_grant),
    .id_o    (pick_id),
    .any_o   (pick_any)
  );

  always_comb begin
    grant   = pick_grant;
    win_id  = pick_id;
    win_any = pick_any;
    ptr_d   = arb_ptr;
    if (pick_any) ptr_d = next_ptr(pick_id);
`ifdef SPRITE_ARB_PRIO0_EN
    if (bus.Req[REQ_PLAYER]) begin
      grant   = {{(NUM_REQ-1){1'b0}}, 1'b1};
      win_id  = REQ_PLAYER;
      win_any = 1'b1;
      ptr_d   = arb_ptr;
    end
`endif
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_q      <= '0;
      rom_addr_q <= '0;
      rom_rden_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      for (int k = 0; k <= ROM_LAT; k++) tag_q[k] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rom_rden_q <= win_any;
      if (win_any) rom_addr_q <= bus.Addr[int'(win_id)*ADDR_W +: ADDR_W];
      // tag rides alongside the ROM read so the data can be returned to its owner
      tag_q[0] <= '{v: win_any, id: win_id};
      for (int k = 1; k <= ROM_LAT; k++) tag_q[k] <= tag_q[k-1];
      if (tag_q[ROM_LAT].v) begin
        rd_data_q  <= bus.RomData;
        rd_valid_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << tag_q[ROM_LAT].id;
      end else begin
        rd_valid_q <= '0;
      end
    end
  end

  always_comb begin
    busy = |rd_valid_q;
    for (int k = 0; k <= ROM_LAT; k++) busy = busy | tag_q[k].v;
  end

  assign bus.Grant   = grant;
  assign bus.RomAddr = rom_addr_q;
  assign bus.RomRden = rom_rden_q;
  assign bus.RdData  = rd_data_q;
  assign bus.RdValid = rd_valid_q;
  assign bus.Busy    = busy;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - scoreboard bench for sprite_rom_arbiter with a 1-cycle ROM model
module tb_sprite_rom_arbiter;

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  sprite_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(14), .DATA_W(6)) bus ();

  sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(14), .DATA_W(6), .ROM_LAT(1)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  typedef struct {
    int         id;
    logic [5:0] d;
    int         cyc;
  } item_t;

  item_t       sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          mptr  = 0;
  logic        exp_rden = 1'b0;
  logic [13:0] exp_raddr = '0;
  logic [13:0] a [4];

  function automatic logic [5:0] rom_f(input logic [13:0] ad);
    return ad[5:0] ^ ad[11:6] ^ {ad[13:12], 4'h5};
  endfunction

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (bus.RomRden) bus.RomData <= rom_f(bus.RomAddr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset_n === 1'b1 && bus.RdValid !== 4'b0000) begin
      if (sb.size() == 0) begin
        chk("spurious_rdvalid", 32'(bus.RdValid), 32'h0);
      end else begin
        item_t it;
        it = sb.pop_front();
        chk("rdvalid", 32'(bus.RdValid), 32'(4'b0001 << it.id));
        chk("rddata", 32'(bus.RdData), 32'(it.d));
        chk("latency", 32'(cyc), 32'(it.cyc + 3));
      end
    end
  end

  function automatic void model(input logic [3:0] req, input logic fs,
                                output logic any, output int id);
    int p;
    p   = fs ? 0 : mptr;
    any = 1'b0;
    id  = 0;
`ifdef SPRITE_ARB_PRIO0_EN
    if (req[0]) begin
      any = 1'b1;
      return;
    end
`endif
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (p + k) % 4;
`ifdef SPRITE_ARB_PRIO0_EN
      if (j == 0) continue;
`endif
      if (!any && req[j]) begin
        any = 1'b1;
        id  = j;
      end
    end
  endfunction

  // called at posedge+1; leaves at the next posedge+1
  task automatic step(input logic [3:0] req, input logic fs);
    logic any;
    int   id;
    chk("romrden", 32'(bus.RomRden), 32'(exp_rden));
    if (exp_rden) chk("romaddr", 32'(bus.RomAddr), 32'(exp_raddr));
    bus.Req        = req;
    bus.FrameStart = fs;
    bus.Addr       = {a[3], a[2], a[1], a[0]};
    #3;
    model(req, fs, any, id);
    chk("grant", 32'(bus.Grant), any ? 32'(4'b0001 << id) : 32'h0);
    if (any) sb.push_back('{id: id, d: rom_f(a[id]), cyc: cyc});
    exp_rden  = any;
    exp_raddr = a[id];
    if (fs) mptr = 0;
`ifdef SPRITE_ARB_PRIO0_EN
    if (any && id != 0) mptr = (id + 1) % 4;
`else
    if (any) mptr = (id + 1) % 4;
`endif
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n        = 1'b0;
    bus.Req        = '0;
    bus.Addr       = '0;
    bus.FrameStart = 1'b0;
    for (int i = 0; i < 4; i++) a[i] = 14'(16'h0100 * (i + 1));
    #3;
    chk("rst_grant", 32'(bus.Grant), 32'h0);
    chk("rst_rden", 32'(bus.RomRden), 32'h0);
    chk("rst_busy", 32'(bus.Busy), 32'h0);
    chk("rst_romaddr", 32'(bus.RomAddr), 32'h0);
    chk("rst_rdvalid", 32'(bus.RdValid), 32'h0);
    chk("rst_rddata", 32'(bus.RdData), 32'h0);
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    // single player read
    a[0] = 14'h0123;
    step(4'b0001, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b0);

    // all requesters, back to back, rotation restarted by FrameStart
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) a[i] = 14'(c * 37 + i * 1000 + 5);
      step(4'b1111, c == 0);
    end
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b0);

    // FrameStart overrides ptr=2, idx1 wins and ptr moves to 2
    step(4'b0010, 1'b0);
    step(4'b0110, 1'b1);
    step(4'b0110, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b0);

    // reset with reads in flight
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    Reset_n = 1'b0;
    bus.Req = 4'b0000;
    #1;
    chk("midrst_rden", 32'(bus.RomRden), 32'h0);
    chk("midrst_rdvalid", 32'(bus.RdValid), 32'h0);
    chk("midrst_busy", 32'(bus.Busy), 32'h0);
    chk("midrst_romaddr", 32'(bus.RomAddr), 32'h0);
    sb.delete();
    exp_rden = 1'b0;
    mptr     = 0;
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b0);
    step(4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b0);

`ifdef SPRITE_ARB_PRIO0_EN
    for (int c = 0; c < 4; c++) step(4'b1101, 1'b0);
    for (int c = 0; c < 3; c++) step(4'b1100, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b0);
`endif

    // Req[3] withdrawn before its turn
    step(4'b1001, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b0);
    chk("idle_busy", 32'(bus.Busy), 32'h0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge Clk);
    chk("drain", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
